// File: rtl/fma_stream_ctrl.sv
// Valid/ready wrapper around a fixed-latency, stall-free FMA pipeline.
// Credits cover in-flight ops plus unread results so a stalled consumer never drops a result.
module fma_stream_ctrl #(
  parameter int LAT   = 5,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [31:0] in_c,
  output logic [31:0] fma_a,
  output logic [31:0] fma_b,
  output logic [31:0] fma_c,
  input  logic [31:0] fma_d,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_d,
  output logic        busy
);
  localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;

  logic [LAT-1:0] vld_sr_q, vld_sr_d;
  logic [AW:0]    inflight_q, inflight_d;
  logic [AW:0]    count_q, count_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [31:0]    mem_q [DEPTH];
  logic [AW+1:0]  occ;
  logic           issue, cap, pop;

  always_comb begin
    // Credit decision uses registered occupancy only, so in_ready never depends on in_valid/out_ready
    occ       = {1'b0, inflight_q} + {1'b0, count_q};
    in_ready  = occ < DEPTH_W;
    out_valid = count_q != '0;
    busy      = (inflight_q != '0) | (count_q != '0);
    out_d     = mem_q[rd_ptr_q];
    issue     = in_valid & in_ready;
    cap       = vld_sr_q[LAT-1];
    pop       = out_valid & out_ready;
    fma_a     = issue ? in_a : 32'h0;
    fma_b     = issue ? in_b : 32'h0;
    fma_c     = issue ? in_c : 32'h0;

    vld_sr_d  = {vld_sr_q[LAT-2:0], issue};

    inflight_d = inflight_q;
    if (issue && !cap)      inflight_d = inflight_q + CNT_ONE;
    else if (cap && !issue) inflight_d = inflight_q - CNT_ONE;

    count_d = count_q;
    if (cap && !pop)      count_d = count_q + CNT_ONE;
    else if (pop && !cap) count_d = count_q - CNT_ONE;

    wr_ptr_d = cap ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_sr_q   <= '0;
      inflight_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      vld_sr_q   <= vld_sr_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage needs no reset: count_q gates visibility of every entry
  always_ff @(posedge clk) begin
    if (!rst && cap) mem_q[wr_ptr_q] <= fma_d;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) occ <= DEPTH_W);

endmodule
